// File: rtl/uart_in_pkg.sv
// Shared constants and types for the simulation UART input responder.
package uart_in_pkg;

    localparam logic [7:0]  UART_IDLE_CH = 8'hFF;
    localparam int unsigned UART_CNT_W   = 32;

    typedef enum logic [0:0] {
        StReady,
        StGap
    } uart_in_state_e;

endpackage

// File: rtl/uart_in_fifo.sv
// Character FIFO: circular buffer with wrapping pointers and a separate occupancy counter.
module uart_in_fifo #(
    parameter int unsigned DEPTH = 16
) (
    input  logic                     clock,
    input  logic                     reset,
    input  logic                     push_valid,
    input  logic [7:0]               push_ch,
    output logic                     push_ready,
    input  logic                     pop,
    output logic [7:0]               head,
    output logic [$clog2(DEPTH):0]   level
);

    localparam int unsigned PtrW = $clog2(DEPTH);
    localparam int unsigned LvlW = PtrW + 1;

    logic [7:0]      mem [DEPTH];
    logic [PtrW-1:0] wr_ptr_q, wr_ptr_d;
    logic [PtrW-1:0] rd_ptr_q, rd_ptr_d;
    logic [LvlW-1:0] level_q, level_d;
    logic            push;

    // Full is judged on the registered level only, so a same-cycle pop never frees a slot.
    assign push_ready = (level_q != LvlW'(DEPTH));
    assign push       = push_valid && push_ready;
    assign head       = mem[rd_ptr_q];
    assign level      = level_q;

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        level_d  = level_q;
        if (push) begin
            wr_ptr_d = wr_ptr_q + PtrW'(1);
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + PtrW'(1);
        end
        case ({push, pop})
            2'b10:   level_d = level_q + LvlW'(1);
            2'b01:   level_d = level_q - LvlW'(1);
            default: level_d = level_q;
        endcase
    end

    always_ff @(posedge clock) begin
        if (!reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            level_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            level_q  <= level_d;
        end
    end

    always_ff @(posedge clock) begin
        if (push) begin
            mem[wr_ptr_q] <= push_ch;
        end
    end

endmodule

// File: rtl/uart_in_responder.sv
// Serves UART read strobes from a host-fed FIFO, with an optional idle gap after each character.
module uart_in_responder
    import uart_in_pkg::*;
#(
    parameter int unsigned DEPTH = 16,
    parameter int unsigned GAP   = 0
) (
    input  logic                    clock,
    input  logic                    reset,
    input  logic                    push_valid,
    input  logic [7:0]              push_ch,
    output logic                    push_ready,
    input  logic                    uart_in_valid,
    output logic [7:0]              uart_in_ch,
    output logic [$clog2(DEPTH):0]  level,
    output logic [UART_CNT_W-1:0]   delivered_cnt,
    output logic [UART_CNT_W-1:0]   empty_reads
);

    localparam int unsigned GapW = (GAP > 1) ? $clog2(GAP) : 1;

    uart_in_state_e        state_q, state_d;
    logic [GapW-1:0]       gap_cnt_q, gap_cnt_d;
    logic [UART_CNT_W-1:0] delivered_cnt_q, delivered_cnt_d;
    logic [UART_CNT_W-1:0] empty_reads_q, empty_reads_d;
    logic [7:0]            head;
    logic                  deliverable;
    logic                  pop;

    uart_in_fifo #(
        .DEPTH (DEPTH)
    ) u_fifo (
        .clock      (clock),
        .reset      (reset),
        .push_valid (push_valid),
        .push_ch    (push_ch),
        .push_ready (push_ready),
        .pop        (pop),
        .head       (head),
        .level      (level)
    );

    // A push this cycle is not visible here: head/level are registered, so no bypass.
    assign deliverable   = (state_q == StReady) && (level != '0);
    assign pop           = uart_in_valid && deliverable;
    assign uart_in_ch    = deliverable ? head : UART_IDLE_CH;
    assign delivered_cnt = delivered_cnt_q;
    assign empty_reads   = empty_reads_q;

    always_comb begin
        state_d   = state_q;
        gap_cnt_d = gap_cnt_q;
        unique case (state_q)
            StReady: begin
                if (pop && (GAP > 0)) begin
                    state_d   = StGap;
                    gap_cnt_d = GapW'(GAP - 1);
                end
            end
            StGap: begin
                if (gap_cnt_q == '0) begin
                    state_d = StReady;
                end else begin
                    gap_cnt_d = gap_cnt_q - GapW'(1);
                end
            end
            default: state_d = StReady;
        endcase
    end

    always_comb begin
        delivered_cnt_d = delivered_cnt_q;
        empty_reads_d   = empty_reads_q;
        if (pop && (delivered_cnt_q != '1)) begin
            delivered_cnt_d = delivered_cnt_q + UART_CNT_W'(1);
        end
        if (uart_in_valid && !deliverable && (empty_reads_q != '1)) begin
            empty_reads_d = empty_reads_q + UART_CNT_W'(1);
        end
    end

    always_ff @(posedge clock) begin
        if (!reset) begin
            state_q         <= StReady;
            gap_cnt_q       <= '0;
            delivered_cnt_q <= '0;
            empty_reads_q   <= '0;
        end else begin
            state_q         <= state_d;
            gap_cnt_q       <= gap_cnt_d;
            delivered_cnt_q <= delivered_cnt_d;
            empty_reads_q   <= empty_reads_d;
        end
    end

endmodule
